// File: rtl/pll_rst_seq.sv
// Reset sequencer for the PLL output clock domain: synchronises PLL lock,
// qualifies it for LOCK_CYCLES, holds reset for HOLD_CYCLES, then releases.
module pll_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 256,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_locked,
  output logic       o_rst,
  output logic       o_rst_n,
  output logic       o_locked_sync,
  output logic [1:0] o_state,
  output logic [7:0] o_loss_count
);

  localparam int MAX_CYCLES = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STABLE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   lk_s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  // i_locked is asynchronous to i_clk; only the last stage is ever consumed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_locked};
    end
  end

  assign lk_s = sync[SYNC_STAGES-1];

  // o_rst/o_rst_n are loaded with the decision for the next state, so they
  // switch on the same edge as the state register without a decode glitch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_WAIT;
      cnt          <= '0;
      o_rst        <= 1'b1;
      o_rst_n      <= 1'b0;
      o_loss_count <= 8'd0;
    end else begin
      o_rst   <= 1'b1;
      o_rst_n <= 1'b0;
      case (state)
        ST_WAIT: begin
          cnt <= '0;
          if (lk_s) begin
            state <= ST_STABLE;
          end
        end
        ST_STABLE: begin
          if (!lk_s) begin
            state <= ST_WAIT;
          end else if (cnt == LOCK_LAST) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (!lk_s) begin
            state <= ST_WAIT;
          end else if (cnt == HOLD_LAST) begin
            state   <= ST_RUN;
            o_rst   <= 1'b0;
            o_rst_n <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lk_s) begin
            state <= ST_WAIT;
            if (o_loss_count != 8'hff) begin
              o_loss_count <= o_loss_count + 8'd1;
            end
          end else begin
            o_rst   <= 1'b0;
            o_rst_n <= 1'b1;
          end
        end
        default: begin
          state <= ST_WAIT;
        end
      endcase
    end
  end

  assign o_locked_sync = lk_s;
  assign o_state       = state;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Randomised scoreboard bench for pll_rst_seq: a lock-streak reference model
// pushes per-edge expectations, a negedge monitor pops and compares them.
module tb_pll_rst_seq;

  localparam int SYNC = 2;
  localparam int LOCK = 8;
  localparam int HOLD = 4;

  typedef struct packed {
    logic       rst;
    logic       rst_n;
    logic       lsync;
    logic [1:0] state;
    logic [7:0] loss;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_drv = 1'b1;
  logic       lock_drv = 1'b0;
  logic       o_rst, o_rst_n, o_locked_sync;
  logic [1:0] o_state;
  logic [7:0] o_loss_count;

  int n_compared = 0;
  int n_mismatched = 0;

  exp_t exp_q[$];

  // reference model state: edge number, per-edge sampled lock, last reset edge
  int edge_n = 0;
  int last_reset = 0;
  int streak = 0;
  int st_prev = 0;
  int loss = 0;
  bit lk_prev = 1'b0;
  bit samp[$];

  pll_rst_seq #(
    .SYNC_STAGES(SYNC),
    .LOCK_CYCLES(LOCK),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_drv),
    .i_locked     (lock_drv),
    .o_rst        (o_rst),
    .o_rst_n      (o_rst_n),
    .o_locked_sync(o_locked_sync),
    .o_state      (o_state),
    .o_loss_count (o_loss_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    n_compared++;
    if (actual !== required) begin
      n_mismatched++;
      $display("[TB] FAIL %s at edge %0d: got %0h, required %0h", name, edge_n, actual, required);
    end
  endtask

  // streak = consecutive synchronised-high edges seen before this edge
  function automatic int state_of(input int s);
    if (s == 0) return 0;
    if (s <= LOCK) return 1;
    if (s <= LOCK + HOLD) return 2;
    return 3;
  endfunction

  task automatic model_step();
    int   idx;
    int   st;
    bit   lk;
    exp_t e;
    edge_n++;
    samp.push_back(lock_drv);
    if (rst_drv) begin
      last_reset = edge_n;
      streak     = 0;
      st         = 0;
      loss       = 0;
    end else begin
      streak = lk_prev ? streak + 1 : 0;
      st     = state_of(streak);
      if (st_prev == 3 && st == 0 && loss < 255) loss++;
    end
    idx = edge_n - SYNC + 1;
    lk  = (idx >= 1 && idx > last_reset) ? samp[idx] : 1'b0;
    e.rst   = (st != 3);
    e.rst_n = (st == 3);
    e.lsync = lk;
    e.state = 2'(st);
    e.loss  = 8'(loss);
    exp_q.push_back(e);
    st_prev = st;
    lk_prev = lk;
  endtask

  task automatic applyStimulus(input logic rst, input logic lock, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst_drv  = rst;
      lock_drv = lock;
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("o_rst", 32'(o_rst), 32'(e.rst));
        checkOutput("o_rst_n", 32'(o_rst_n), 32'(e.rst_n));
        checkOutput("o_locked_sync", 32'(o_locked_sync), 32'(e.lsync));
        checkOutput("o_state", 32'(o_state), 32'(e.state));
        checkOutput("o_loss_count", 32'(o_loss_count), 32'(e.loss));
        checkOutput("rst_low_only_in_run", 32'(o_rst === 1'b0 && o_state !== 2'd3), 32'd0);
      end
    end
  end

  initial begin : stimulus
    samp.push_back(1'b0);

    // release timing
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("reset_o_rst", 32'(o_rst), 32'd1);
    checkOutput("reset_o_state", 32'(o_state), 32'd0);
    applyStimulus(1'b0, 1'b1, 14);
    checkOutput("release_e14_o_rst", 32'(o_rst), 32'd1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("release_e15_o_rst", 32'(o_rst), 32'd0);
    checkOutput("release_e15_o_rst_n", 32'(o_rst_n), 32'd1);
    checkOutput("release_e15_o_state", 32'(o_state), 32'd3);

    // one-cycle glitch during STABLE restarts the full count
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b1, 5);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 14);
    checkOutput("glitch_e20_o_rst", 32'(o_rst), 32'd1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("glitch_e21_o_rst", 32'(o_rst), 32'd0);
    checkOutput("glitch_loss", 32'(o_loss_count), 32'd0);

    // loss of lock in RUN
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("loss_k_o_rst", 32'(o_rst), 32'd0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("loss_k1_o_rst", 32'(o_rst), 32'd0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("loss_k2_o_rst", 32'(o_rst), 32'd1);
    checkOutput("loss_k2_o_state", 32'(o_state), 32'd0);
    checkOutput("loss_k2_count", 32'(o_loss_count), 32'd1);
    applyStimulus(1'b0, 1'b1, 15);
    checkOutput("relock_o_rst", 32'(o_rst), 32'd0);

    // reset during HOLD
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 11);
    checkOutput("hold_o_state", 32'(o_state), 32'd2);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("rst_in_hold_o_rst", 32'(o_rst), 32'd1);
    checkOutput("rst_in_hold_o_state", 32'(o_state), 32'd0);
    checkOutput("rst_in_hold_lsync", 32'(o_locked_sync), 32'd0);
    checkOutput("rst_in_hold_loss", 32'(o_loss_count), 32'd0);
    applyStimulus(1'b0, 1'b1, 14);
    checkOutput("after_rst_e14_o_rst", 32'(o_rst), 32'd1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("after_rst_e15_o_rst", 32'(o_rst), 32'd0);

    // saturation of the loss counter
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b0, 1'b1, 15 + int'($urandom_range(0, 3)));
      applyStimulus(1'b0, 1'b0, 3 + int'($urandom_range(0, 3)));
    end
    checkOutput("saturated_loss", 32'(o_loss_count), 32'd255);

    // randomised lock/unlock/reset segments
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 7) == 0), 1'($urandom), int'($urandom_range(1, 20)));
    end

    // never locked
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 10000);
    checkOutput("never_locked_o_rst", 32'(o_rst), 32'd1);
    checkOutput("never_locked_o_state", 32'(o_state), 32'd0);

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
